btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//  Per-button front end for the clock's mode/adjust push-buttons. Synchronises raw pad inputs,
//  debounces them, and produces a clean pressed level plus press/release/click/long-press/auto-repeat
//  strobes. btn_level feeds the display/edit state machine, which acts on its falling edge.
//  The repeat strobe drives field-increment logic in the edit states.
// PARAMETERS
//  NUM_BTN          2           number of independent button channels
//  ACTIVE_LOW       1           1: raw pad reads 0 when pressed; 0: reads 1 when pressed
//  DEBOUNCE_CYCLES  1_000_000   cycles the synced input must differ from btn_level before it flips (20 ms @ 50 MHz)
//  LONG_CYCLES      50_000_000  held cycles before a press counts as long (1 s @ 50 MHz)
//  REPEAT_CYCLES    10_000_000  auto-repeat period once long (200 ms @ 50 MHz); all three counts >= 2
// PORTS
//  clk            in   1        system clock
//  rst_n          in   1        asynchronous reset, active-low
//  btn_raw        in   NUM_BTN  raw asynchronous pad levels
//  btn_level      out  NUM_BTN  debounced level, 1 = pressed
//  press_pulse    out  NUM_BTN  1-cycle strobe, first cycle btn_level is 1
//  release_pulse  out  NUM_BTN  1-cycle strobe, first cycle btn_level is 0
//  click_pulse    out  NUM_BTN  1-cycle strobe with release_pulse, only if long_held was 0
//  long_pulse     out  NUM_BTN  1-cycle strobe when hold reaches LONG_CYCLES
//  repeat_pulse   out  NUM_BTN  1-cycle strobes: with long_pulse, then every REPEAT_CYCLES while held
//  long_held      out  NUM_BTN  level: 1 from long_pulse cycle until release
// BEHAVIOUR
//  - Reset: all outputs 0, sync flops load the released level, counters 0, FSM IDLE.
//  - Sync: 2-FF synchroniser, then polarity fold (pressed = 1). All later logic sees synced value only.
//  - Debounce: counter clears whenever synced == btn_level; otherwise increments. When count reaches
//    DEBOUNCE_CYCLES-1 with input still differing, btn_level toggles next edge and counter clears.
//    Latency raw edge -> btn_level edge = 2 + DEBOUNCE_CYCLES clocks. Glitches < DEBOUNCE_CYCLES cycles
//    produce no output change. Same rule in both directions.
//  - Hold FSM per channel: IDLE -> SHORT on btn_level rise; SHORT -> LONG when hold counter hits
//    LONG_CYCLES; SHORT/LONG -> IDLE on btn_level fall.
//  - Timing, t0 = press_pulse cycle: long_pulse, long_held rise, first repeat_pulse at t0+LONG_CYCLES;
//    further repeat_pulse at t0+LONG_CYCLES+k*REPEAT_CYCLES, k>=1, while held.
//  - Release: release_pulse same cycle btn_level falls; long_held falls same cycle; click_pulse only from
//    SHORT. Hold/repeat counters clear; no long/repeat strobe on or after the release cycle.
//  - Hold counter saturates at LONG_CYCLES; repeat counter wraps at REPEAT_CYCLES-1 -> 0.
//  - Channels fully independent; simultaneous events on several channels all reported same cycle.
//  - Reset mid-hold: outputs drop asynchronously. If pad still pressed after reset, normal debounce
//    applies and a fresh press_pulse follows; long timer restarts from 0.
//  - Counter widths: $clog2 of the respective max count; no wrap beyond stated limits.
// STRUCTURE
//  - btn_pkg: hold-FSM state encoding (IDLE/SHORT/LONG), default cycle constants for 50 MHz.
//  - Sub-module btn_channel: one sync+debounce+hold-FSM channel; top instantiates NUM_BTN via generate.
// TESTING  (bench params: NUM_BTN=2, ACTIVE_LOW=1, DEBOUNCE=4, LONG=16, REPEAT=5)
//  1 Reset with btn_raw[0]=0 (pressed) held -> outputs 0 in reset; btn_level[0] rises 6 clocks after rst_n release, press_pulse same cycle.
//  2 btn_raw[0] low for 3 cycles then high -> no output activity; low for 12 cycles -> press at +6, release/click 6 after raw rise.
//  3 Short click (level high 10 cycles) -> press_pulse t0, release_pulse+click_pulse t0+10, no long/repeat.
//  4 Hold 30 cycles -> long_pulse+repeat t0+16, repeat t0+21, t0+26; release t0+30: release_pulse, long_held 0, no click.
//  5 Both channels pressed same cycle, ch1 released mid-debounce of ch0 -> independent, same-cycle strobes correct.
//  6 rst_n pulse low at t0+20 during long hold, pad still pressed -> outputs 0 immediately; new press 6 after reset, long at +16.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: hold-FSM encoding and
// default timing constants for a 50 MHz system clock.
package btn_pkg;

  typedef enum logic [1:0] {
    HOLD_IDLE  = 2'd0,
    HOLD_SHORT = 2'd1,
    HOLD_LONG  = 2'd2
  } hold_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms
  localparam int unsigned DEF_LONG_CYCLES     = 50_000_000; // 1 s
  localparam int unsigned DEF_REPEAT_CYCLES   = 10_000_000; // 200 ms

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, symmetric debounce counter and a
// hold FSM producing press/release/click/long/repeat strobes.
module btn_channel
  import btn_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic long_held
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int unsigned REP_W  = $clog2(REPEAT_CYCLES);

  localparam logic              RELEASED = ACTIVE_LOW;
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic              sync1_q, sync2_q;
  logic              level_q, level_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  hold_state_e       state_q, state_d;
  logic              pressed;
  logic              long_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= RELEASED;
      sync2_q    <= RELEASED;
      level_q    <= 1'b0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HOLD_IDLE;
    else        state_q <= state_d;
  end

  // Counter restarts on any cycle where the input agrees with the current level.
  always_comb begin
    pressed   = sync2_q ^ RELEASED;
    level_d   = level_q;
    deb_cnt_d = '0;
    if (pressed != level_q) begin
      if (deb_cnt_q == DEB_LAST) level_d   = ~level_q;
      else                       deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_comb begin
    hold_cnt_d = '0;
    if (level_q) hold_cnt_d = (hold_cnt_q == LONG_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
    rep_cnt_d = '0;
    if (state_q == HOLD_LONG && level_q && rep_cnt_q != REP_LAST) rep_cnt_d = rep_cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD_IDLE:  if (level_q) state_d = HOLD_SHORT;
      HOLD_SHORT: begin
        if (!level_q)                      state_d = HOLD_IDLE;
        else if (hold_cnt_q == LONG_MAX)   state_d = HOLD_LONG;
      end
      HOLD_LONG:  if (!level_q) state_d = HOLD_IDLE;
      default:    state_d = HOLD_IDLE;
    endcase
  end

  // Every hold-related strobe is gated by level_q so none fires on the release cycle.
  always_comb begin
    long_hit      = (state_q == HOLD_SHORT) && level_q && (hold_cnt_q == LONG_MAX);
    btn_level     = level_q;
    press_pulse   = (state_q == HOLD_IDLE) && level_q;
    release_pulse = (state_q != HOLD_IDLE) && !level_q;
    click_pulse   = (state_q == HOLD_SHORT) && !level_q;
    long_pulse    = long_hit;
    repeat_pulse  = long_hit || ((state_q == HOLD_LONG) && level_q && (rep_cnt_q == REP_LAST));
    long_held     = level_q && ((state_q == HOLD_LONG) || long_hit);
  end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-button front end: one independent btn_channel per pad producing a
// debounced level plus press/release/click/long/repeat strobes.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 2,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] click_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse,
  output logic [NUM_BTN-1:0] long_held
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_raw       (btn_raw[i]),
      .btn_level     (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .click_pulse   (click_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .long_held     (long_held[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with short debounce/long/repeat counts.
module tb_btn_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 16;
  localparam int REP  = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_level, press_pulse, release_pulse, click_pulse;
  logic [1:0] long_pulse, repeat_pulse, long_held;

  always #5 clk = ~clk;

  btn_conditioner #(
    .NUM_BTN         (2),
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .click_pulse   (click_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .long_held     (long_held)
  );

  typedef struct packed {
    logic level, press, rel, click, lng, rpt, held;
  } ch_out_t;

  typedef struct {
    int      id;
    int      cyc;
    ch_out_t c0;
    ch_out_t c1;
  } exp_t;

  // Pad held low on channel x for cycles [ax, ax+dx); expected phase totals.
  typedef struct {
    int a0, d0, a1, d1, len;
    int clk0, clk1, rep0, rep1;
  } phase_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   click_seen[2];
  int   rep_seen[2];

  // Reference from the timing description: press at a+DEB+2, release at a+d+DEB+2.
  function automatic ch_out_t model(int n, int a, int d);
    ch_out_t o;
    int t0, tr;
    bit lp;
    o  = '0;
    t0 = a + DEB + 2;
    tr = a + d + DEB + 2;
    lp = (d > LONG);
    if (d >= DEB) begin
      o.level = (n >= t0) && (n < tr);
      o.press = (n == t0);
      o.rel   = (n == tr);
      o.click = (n == tr) && !lp;
      o.lng   = lp && (n == t0 + LONG);
      o.held  = lp && (n >= t0 + LONG) && (n < tr);
      o.rpt   = o.held && (((n - t0 - LONG) % REP) == 0);
    end
    return o;
  endfunction

  function automatic ch_out_t act_ch(int i);
    ch_out_t o;
    o = {btn_level[i], press_pulse[i], release_pulse[i], click_pulse[i],
         long_pulse[i], repeat_pulse[i], long_held[i]};
    return o;
  endfunction

  always @(negedge clk) begin
    exp_t    e;
    ch_out_t got, want;
    for (int c = 0; c < 2; c++) begin
      if (click_pulse[c])  click_seen[c]++;
      if (repeat_pulse[c]) rep_seen[c]++;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int c = 0; c < 2; c++) begin
        got  = act_ch(c);
        want = (c == 0) ? e.c0 : e.c1;
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL outputs phase%0d cyc%0d ch%0d: lvl/prs/rel/clk/lng/rpt/held got %b expected %b",
                   e.id, e.cyc, c, got, want);
        end
      end
    end
  end

  task automatic check_count(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic push_zero(input int id, input int cyc);
    sb.push_back('{id, cyc, ch_out_t'('0), ch_out_t'('0)});
  endtask

  task automatic run_phase(input phase_t p, input int id);
    click_seen = '{0, 0};
    rep_seen   = '{0, 0};
    for (int n = 0; n < p.len; n++) begin
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      btn_raw[0] = !((n >= p.a0) && (n < p.a0 + p.d0));
      btn_raw[1] = !((n >= p.a1) && (n < p.a1 + p.d1));
      sb.push_back('{id, n, model(n, p.a0, p.d0), model(n, p.a1, p.d1)});
    end
    @(negedge clk);
    #1;
    check_count($sformatf("click_count phase%0d ch0", id), click_seen[0], p.clk0);
    check_count($sformatf("click_count phase%0d ch1", id), click_seen[1], p.clk1);
    check_count($sformatf("repeat_count phase%0d ch0", id), rep_seen[0], p.rep0);
    check_count($sformatf("repeat_count phase%0d ch1", id), rep_seen[1], p.rep1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    phase_t tbl[8];
    phase_t hold_a, hold_b;

    tbl[0] = '{0, 10, 0, 0, 25, 1, 0, 0, 0};  // pad pressed through reset release
    tbl[1] = '{2, 3, 0, 0, 15, 0, 0, 0, 0};   // 3-cycle glitch, no activity
    tbl[2] = '{2, 12, 0, 0, 30, 1, 0, 0, 0};  // 12-cycle press
    tbl[3] = '{2, 10, 0, 0, 30, 1, 0, 0, 0};  // short click, level high 10 cycles
    tbl[4] = '{2, 30, 0, 0, 45, 0, 0, 3, 0};  // 30-cycle hold, three repeats
    tbl[5] = '{2, 12, 2, 10, 30, 1, 1, 0, 0}; // ch1 released during ch0 release debounce
    tbl[6] = '{2, 20, 2, 20, 40, 0, 0, 1, 1}; // simultaneous long presses
    tbl[7] = '{2, 16, 2, 17, 35, 1, 0, 0, 1}; // release just before / just after long
    hold_a = '{0, 1000, 0, 0, 26, 0, 0, 1, 0};
    hold_b = '{0, 30, 0, 0, 45, 0, 0, 3, 0};

    rst_n   = 1'b0;
    btn_raw = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      push_zero(100, i);
    end

    for (int i = 0; i < 8; i++) run_phase(tbl[i], i);

    run_phase(hold_a, 8);
    // Asynchronous reset with the pad still pressed, long hold in progress.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      push_zero(101, i);
    end
    run_phase(hold_b, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
